regfile_wb_arbiter: RTL

Shares the register block's single write port between two writeback requesters, the ALU path (A) and the load path (M). A registered valid/ready handshake carries the grant, with round-robin priority between the two. The block also keeps a 32-entry busy scoreboard so decode can detect read-after-write hazards on read_reg1/read_reg2. It sits between the execute/memory stages and the register block, and drives its regWrite/write_reg/write_data/byteOperations inputs.

---
 rtl/regfile_wb_arbiter_if.sv | 42 ++++
 rtl/regfile_wb_arbiter.sv | 70 +++++++
 2 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: writeback requests, scoreboard and register-block write port bundle
// Ports (slave = arbiter view):
//   a_*/m_* : ALU and load writeback requests (valid/ready/reg/data/byte)
//   issue_* : decode destination reservation; read_reg1/2 -> hazard
//   regWrite/write_reg/write_data/byteOperations : register block write port
//   busy    : scoreboard vector
interface regfile_wb_arbiter_if #(parameter int NREGS = 32, parameter int DATA_W = 32);
  logic              a_valid;
  logic              a_ready;
  logic [4:0]        a_reg;
  logic [DATA_W-1:0] a_data;
  logic              a_byte;
  logic              m_valid;
  logic              m_ready;
  logic [4:0]        m_reg;
  logic [DATA_W-1:0] m_data;
  logic              m_byte;
  logic              issue_valid;
  logic [4:0]        issue_reg;
  logic [4:0]        read_reg1;
  logic [4:0]        read_reg2;
  logic              hazard;
  logic              regWrite;
  logic [4:0]        write_reg;
  logic [DATA_W-1:0] write_data;
  logic              byteOperations;
  logic [NREGS-1:0]  busy;
  modport slave (
    input  a_valid, a_reg, a_data, a_byte,
    input  m_valid, m_reg, m_data, m_byte,
    input  issue_valid, issue_reg, read_reg1, read_reg2,
    output a_ready, m_ready, hazard,
    output regWrite, write_reg, write_data, byteOperations, busy
  );
  modport master (
    output a_valid, a_reg, a_data, a_byte,
    output m_valid, m_reg, m_data, m_byte,
    output issue_valid, issue_reg, read_reg1, read_reg2,
    input  a_ready, m_ready, hazard,
    input  regWrite, write_reg, write_data, byteOperations, busy
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin share of the register write port between ALU and load paths, plus busy scoreboard
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : regfile_wb_arbiter_if.slave (requests, scoreboard, register write port)
module regfile_wb_arbiter #(
  parameter int NREGS  = 32,
  parameter int DATA_W = 32
) (
  input logic                 clk,
  input logic                 rst_n,
  regfile_wb_arbiter_if.slave bus
);
  logic              last_m_q, last_m_d;
  logic              rw_q, rw_d;
  logic [4:0]        wr_q, wr_d;
  logic [DATA_W-1:0] wd_q, wd_d;
  logic              bo_q, bo_d;
  logic [NREGS-1:0]  busy_q, busy_d;
  logic              gnt_a, gnt_m, xfer, sel_byte;
  logic [4:0]        sel_reg;
  logic [DATA_W-1:0] sel_data;
  // A wins when alone, or when contested and M won last time
  assign gnt_a    = bus.a_valid && (!bus.m_valid || last_m_q);
  assign gnt_m    = bus.m_valid && !gnt_a;
  assign xfer     = gnt_a || gnt_m;
  assign sel_reg  = gnt_a ? bus.a_reg  : bus.m_reg;
  assign sel_data = gnt_a ? bus.a_data : bus.m_data;
  assign sel_byte = gnt_a ? bus.a_byte : bus.m_byte;
  assign bus.a_ready = gnt_a;
  assign bus.m_ready = gnt_m;
  always_comb begin
    last_m_d = xfer ? gnt_m : last_m_q;
    rw_d     = xfer && sel_reg != 5'd0;
    wr_d     = xfer ? sel_reg : wr_q;
    wd_d     = !xfer ? wd_q : sel_byte ? {{(DATA_W-8){1'b0}}, sel_data[7:0]} : sel_data;
    bo_d     = xfer ? sel_byte : bo_q;
  end
  // Clear applied before set so a same-cycle reissue keeps the register busy
  always_comb begin
    busy_d = busy_q;
    if (xfer) busy_d[sel_reg] = 1'b0;
    if (bus.issue_valid) busy_d[bus.issue_reg] = 1'b1;
    busy_d[0] = 1'b0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_m_q <= 1'b1;
      rw_q     <= 1'b0;
      wr_q     <= '0;
      wd_q     <= '0;
      bo_q     <= 1'b0;
      busy_q   <= '0;
    end else begin
      last_m_q <= last_m_d;
      rw_q     <= rw_d;
      wr_q     <= wr_d;
      wd_q     <= wd_d;
      bo_q     <= bo_d;
      busy_q   <= busy_d;
    end
  end
  assign bus.hazard = (bus.read_reg1 != 5'd0 && busy_q[bus.read_reg1]) ||
                      (bus.read_reg2 != 5'd0 && busy_q[bus.read_reg2]);
  assign bus.regWrite       = rw_q;
  assign bus.write_reg      = wr_q;
  assign bus.write_data     = wd_q;
  assign bus.byteOperations = bo_q;
  assign bus.busy           = busy_q;
endmodule
